// File: rtl/rdma_sq_entry_parser_if.sv
// rdma_sq_entry_parser_if: AXI4-Stream slave bus carrying SQ entry beats.
// The master side drives beats and the parser drives TREADY back.
interface rdma_sq_entry_parser_if #(
    parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32
);
    logic                              TVALID;
    logic                              TREADY;
    logic [C_S_AXIS_TDATA_WIDTH-1:0]   TDATA;
    logic [C_S_AXIS_TDATA_WIDTH/8-1:0] TSTRB;
    logic                              TLAST;

    modport master (
        output TVALID,
        output TDATA,
        output TSTRB,
        output TLAST,
        input  TREADY
    );

    modport slave (
        input  TVALID,
        input  TDATA,
        input  TSTRB,
        input  TLAST,
        output TREADY
    );
endinterface

// File: rtl/rdma_sq_entry_parser.sv
// rdma_sq_entry_parser: assembles fixed-size SQ entries from an AXI4-Stream of
// any supported width and decodes them into RDMA descriptor fields, held in an
// output stage behind a valid/ready handshake.
// Build option RDMA_SQ_TLAST_CHECK_EN: when defined, TLAST framing is checked
// (frame_err pulse, early-TLAST discard, DRAIN recovery on missing TLAST);
// when undefined, entries are delimited by beat count alone.
module rdma_sq_entry_parser #(
    parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned ENTRY_BYTES          = 64
) (
    input  logic                          S_AXIS_ACLK,
    input  logic                          S_AXIS_ARESETN,
    rdma_sq_entry_parser_if.slave         S_AXIS,
    output logic [31:0]                   rdma_id,
    output logic [15:0]                   rdma_opcode,
    output logic [15:0]                   rdma_flags,
    output logic [63:0]                   rdma_local_key,
    output logic [63:0]                   rdma_remote_key,
    output logic [127:0]                  rdma_btt,
    output logic [(ENTRY_BYTES-40)*8-1:0] rdma_reserved,
    output logic                          rdma_entry_valid,
    input  logic                          rdma_entry_ready,
    output logic                          frame_err,
    output logic [31:0]                   entry_count
);
    localparam int unsigned W     = C_S_AXIS_TDATA_WIDTH;
    localparam int unsigned ENT_W = ENTRY_BYTES * 8;
    localparam int unsigned BEATS = ENT_W / W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    localparam logic [0:0] ST_RECV  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_beat_cnt;
    logic [ENT_W-1:0] r_out;
    logic             r_valid;
    logic             r_frame_err;
    logic [31:0]      r_entry_count;

    logic             w_accept;
    logic             w_last_beat;
    logic             w_stall;
    logic [ENT_W-1:0] w_entry;
    logic             w_unused;

    assign w_last_beat = (r_beat_cnt == LAST_CNT);
    // Only a completing beat that would overwrite an unconsumed entry is held off.
    assign w_stall       = (r_state == ST_RECV) & w_last_beat & r_valid & ~rdma_entry_ready;
    assign S_AXIS.TREADY = ~w_stall;
    assign w_accept      = S_AXIS.TVALID & ~w_stall;

    assign w_unused = ^S_AXIS.TSTRB;

    // The final beat is never stored: it is merged straight from TDATA on completion.
    if (BEATS > 1) begin : g_buf
        logic [(BEATS-1)*W-1:0] r_buf;

        // Capture every non-final beat into its slot of the assembly buffer.
        always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
            if (!S_AXIS_ARESETN) begin
                r_buf <= '0;
            end else if (w_accept && (r_state == ST_RECV) && !w_last_beat) begin
                for (int unsigned b = 0; b < BEATS - 1; b++) begin
                    if (r_beat_cnt == b[CNT_W-1:0]) begin
                        r_buf[b*W +: W] <= S_AXIS.TDATA;
                    end
                end
            end
        end

        assign w_entry = {S_AXIS.TDATA, r_buf};
    end else begin : g_nobuf
        assign w_entry = S_AXIS.TDATA;
    end

    // Framing FSM, beat counter, output hold stage and entry counter.
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            r_state       <= ST_RECV;
            r_beat_cnt    <= '0;
            r_out         <= '0;
            r_valid       <= 1'b0;
            r_frame_err   <= 1'b0;
            r_entry_count <= '0;
        end else begin
            r_frame_err <= 1'b0;
            if (r_valid && rdma_entry_ready) begin
                r_valid <= 1'b0;
            end
            if (w_accept) begin
                if (r_state == ST_DRAIN) begin
                    if (S_AXIS.TLAST) begin
                        r_state    <= ST_RECV;
                        r_beat_cnt <= '0;
                    end
                end else if (w_last_beat) begin
                    r_beat_cnt <= '0;
`ifdef RDMA_SQ_TLAST_CHECK_EN
                    if (!S_AXIS.TLAST) begin
                        r_frame_err <= 1'b1;
                        r_state     <= ST_DRAIN;
                    end else
`endif
                    begin
                        // A completion overrides the clear above, so valid stays high.
                        r_out         <= w_entry;
                        r_valid       <= 1'b1;
                        r_entry_count <= r_entry_count + 32'd1;
                    end
                end else begin
`ifdef RDMA_SQ_TLAST_CHECK_EN
                    if (S_AXIS.TLAST) begin
                        r_frame_err <= 1'b1;
                        r_beat_cnt  <= '0;
                    end else
`endif
                    begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign rdma_id          = r_out[31:0];
    assign rdma_opcode      = r_out[47:32];
    assign rdma_flags       = r_out[63:48];
    assign rdma_local_key   = r_out[127:64];
    assign rdma_remote_key  = r_out[191:128];
    assign rdma_btt         = r_out[319:192];
    assign rdma_reserved    = r_out[ENT_W-1:320];
    assign rdma_entry_valid = r_valid;
    assign frame_err        = r_frame_err;
    assign entry_count      = r_entry_count;
endmodule

// File: tb/tb_rdma_sq_entry_parser.sv
// tb_rdma_sq_entry_parser: directed vectors for 32-, 128- and 512-bit parsers
// with 64-byte entries; entry words are seed+i, little-endian.
module tb_rdma_sq_entry_parser;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rdma_sq_entry_parser_if #(.C_S_AXIS_TDATA_WIDTH(32))  a32 ();
    rdma_sq_entry_parser_if #(.C_S_AXIS_TDATA_WIDTH(128)) a128 ();
    rdma_sq_entry_parser_if #(.C_S_AXIS_TDATA_WIDTH(512)) a512 ();

    logic [31:0]  id32, id128, id512;
    logic [15:0]  op32, op128, op512, fl32, fl128, fl512;
    logic [63:0]  lk32, lk128, lk512, rk32, rk128, rk512;
    logic [127:0] bt32, bt128, bt512;
    logic [191:0] rs32, rs128, rs512;
    logic         v32, v128, v512, rdy32, rdy128, rdy512;
    logic         fe32, fe128, fe512;
    logic [31:0]  cnt32, cnt128, cnt512;

    rdma_sq_entry_parser #(.C_S_AXIS_TDATA_WIDTH(32), .ENTRY_BYTES(64)) u_dut32 (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .S_AXIS(a32),
        .rdma_id(id32), .rdma_opcode(op32), .rdma_flags(fl32),
        .rdma_local_key(lk32), .rdma_remote_key(rk32), .rdma_btt(bt32),
        .rdma_reserved(rs32), .rdma_entry_valid(v32), .rdma_entry_ready(rdy32),
        .frame_err(fe32), .entry_count(cnt32));

    rdma_sq_entry_parser #(.C_S_AXIS_TDATA_WIDTH(128), .ENTRY_BYTES(64)) u_dut128 (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .S_AXIS(a128),
        .rdma_id(id128), .rdma_opcode(op128), .rdma_flags(fl128),
        .rdma_local_key(lk128), .rdma_remote_key(rk128), .rdma_btt(bt128),
        .rdma_reserved(rs128), .rdma_entry_valid(v128), .rdma_entry_ready(rdy128),
        .frame_err(fe128), .entry_count(cnt128));

    rdma_sq_entry_parser #(.C_S_AXIS_TDATA_WIDTH(512), .ENTRY_BYTES(64)) u_dut512 (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .S_AXIS(a512),
        .rdma_id(id512), .rdma_opcode(op512), .rdma_flags(fl512),
        .rdma_local_key(lk512), .rdma_remote_key(rk512), .rdma_btt(bt512),
        .rdma_reserved(rs512), .rdma_entry_valid(v512), .rdma_entry_ready(rdy512),
        .frame_err(fe512), .entry_count(cnt512));

    typedef struct {
        logic [31:0]  seed;
        logic [31:0]  id;
        logic [15:0]  op;
        logic [15:0]  fl;
        logic [63:0]  lk;
        logic [63:0]  rk;
        logic [127:0] btt;
        logic [31:0]  res_lo;
        logic [31:0]  res_hi;
    } vec_t;

    vec_t vt [4];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned n_ferr = 0;
    int unsigned exp_ferr = 0;
    int unsigned exp32 = 0, exp128 = 0, exp512 = 0;

    // Count frame_err pulses seen on the 32-bit parser.
    always @(negedge clk) if (fe32 === 1'b1) n_ferr++;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_ent(input string tag, input vec_t v,
                           input logic [31:0] id, input logic [15:0] op, input logic [15:0] fl,
                           input logic [63:0] lk, input logic [63:0] rk, input logic [127:0] bt,
                           input logic [191:0] rs);
        chk({tag, ".id"}, id, v.id);
        chk({tag, ".opcode"}, op, v.op);
        chk({tag, ".flags"}, fl, v.fl);
        chk({tag, ".lkey"}, lk, v.lk);
        chk({tag, ".rkey"}, rk, v.rk);
        chk({tag, ".btt"}, bt, v.btt);
        chk({tag, ".res_lo"}, rs[31:0], v.res_lo);
        chk({tag, ".res_hi"}, rs[191:160], v.res_hi);
    endtask

    function automatic logic [511:0] mk_entry(input logic [31:0] seed);
        logic [511:0] e;
        for (int unsigned j = 0; j < 16; j++) e[j*32 +: 32] = seed + j;
        return e;
    endfunction

    // Each beat task presents a beat, waits (bounded) for TREADY, and returns
    // #1 after the accepting edge.
    task automatic beat32(input logic [31:0] d, input logic last);
        int unsigned t = 0;
        a32.TVALID = 1'b1; a32.TDATA = d; a32.TLAST = last;
        @(negedge clk);
        while (!a32.TREADY && t < 200) begin t++; @(negedge clk); end
        if (!a32.TREADY) begin
            n_cmp++; n_err++;
            $display("FAIL beat32.timeout: TREADY stuck at 0, required 1");
        end
        @(posedge clk); #1;
        a32.TVALID = 1'b0; a32.TLAST = 1'b0;
    endtask

    task automatic beat128(input logic [127:0] d, input logic last);
        int unsigned t = 0;
        a128.TVALID = 1'b1; a128.TDATA = d; a128.TLAST = last;
        @(negedge clk);
        while (!a128.TREADY && t < 200) begin t++; @(negedge clk); end
        if (!a128.TREADY) begin
            n_cmp++; n_err++;
            $display("FAIL beat128.timeout: TREADY stuck at 0, required 1");
        end
        @(posedge clk); #1;
        a128.TVALID = 1'b0; a128.TLAST = 1'b0;
    endtask

    task automatic beat512(input logic [511:0] d, input logic last);
        int unsigned t = 0;
        a512.TVALID = 1'b1; a512.TDATA = d; a512.TLAST = last;
        @(negedge clk);
        while (!a512.TREADY && t < 200) begin t++; @(negedge clk); end
        if (!a512.TREADY) begin
            n_cmp++; n_err++;
            $display("FAIL beat512.timeout: TREADY stuck at 0, required 1");
        end
        @(posedge clk); #1;
        a512.TVALID = 1'b0; a512.TLAST = 1'b0;
    endtask

    // nbeats words starting at seed; TLAST on beat index last_at (none if out of range).
    task automatic send32(input logic [31:0] seed, input int unsigned nbeats, input int unsigned last_at);
        for (int unsigned b = 0; b < nbeats; b++) beat32(seed + b, b == last_at);
    endtask

    task automatic send128(input logic [31:0] seed);
        logic [511:0] e;
        e = mk_entry(seed);
        for (int unsigned k = 0; k < 4; k++) beat128(e[k*128 +: 128], k == 3);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{32'h0000_0000, 32'h0000_0000, 16'h0001, 16'h0000,
                  64'h00000003_00000002, 64'h00000005_00000004,
                  128'h00000009_00000008_00000007_00000006, 32'h0000_000A, 32'h0000_000F};
        vt[1] = '{32'h1234_0000, 32'h1234_0000, 16'h0001, 16'h1234,
                  64'h12340003_12340002, 64'h12340005_12340004,
                  128'h12340009_12340008_12340007_12340006, 32'h1234_000A, 32'h1234_000F};
        vt[2] = '{32'hFFFF_FFF0, 32'hFFFF_FFF0, 16'hFFF1, 16'hFFFF,
                  64'hFFFFFFF3_FFFFFFF2, 64'hFFFFFFF5_FFFFFFF4,
                  128'hFFFFFFF9_FFFFFFF8_FFFFFFF7_FFFFFFF6, 32'hFFFF_FFFA, 32'hFFFF_FFFF};
        vt[3] = '{32'hA5A5_0100, 32'hA5A5_0100, 16'h0101, 16'hA5A5,
                  64'hA5A50103_A5A50102, 64'hA5A50105_A5A50104,
                  128'hA5A50109_A5A50108_A5A50107_A5A50106, 32'hA5A5_010A, 32'hA5A5_010F};

        a32.TVALID = 1'b0;  a32.TDATA = '0;  a32.TSTRB = '1;  a32.TLAST = 1'b0;
        a128.TVALID = 1'b0; a128.TDATA = '0; a128.TSTRB = '1; a128.TLAST = 1'b0;
        a512.TVALID = 1'b0; a512.TDATA = '0; a512.TSTRB = '1; a512.TLAST = 1'b0;
        rdy32 = 1'b1; rdy128 = 1'b1; rdy512 = 1'b1;
        rst_n = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", v32, 0);
        chk("rst.count", cnt32, 0);
        chk("rst.tready", a32.TREADY, 1);
        chk("rst.frame_err", fe32, 0);
        chk("rst.id", id32, 0);
        rst_n = 1'b1;

        // Table: each vector through the 32- and 128-bit parsers.
        for (int i = 0; i < 4; i++) begin
            send32(vt[i].seed, 16, 15);
            exp32++;
            chk("v32.valid", v32, 1);
            chk_ent("v32", vt[i], id32, op32, fl32, lk32, rk32, bt32, rs32);
            chk("v32.count", cnt32, exp32);
            @(posedge clk); #1;
            chk("v32.valid_clr", v32, 0);

            send128(vt[i].seed);
            exp128++;
            chk("v128.valid", v128, 1);
            chk_ent("v128", vt[i], id128, op128, fl128, lk128, rk128, bt128, rs128);
            chk("v128.count", cnt128, exp128);
            @(posedge clk); #1;
            chk("v128.valid_clr", v128, 0);
        end

        // 512-bit: every beat is an entry, back to back with valid held high.
        for (int i = 0; i < 4; i++) begin
            beat512(mk_entry(vt[i].seed), 1'b1);
            exp512++;
            chk("v512.valid", v512, 1);
            chk_ent("v512", vt[i], id512, op512, fl512, lk512, rk512, bt512, rs512);
            chk("v512.count", cnt512, exp512);
        end
        @(posedge clk); #1;
        chk("v512.valid_clr", v512, 0);

        // Stall: entry 1 held, entry 2 blocked on its final beat until ready.
        rdy32 = 1'b0;
        send32(vt[1].seed, 16, 15);
        exp32++;
        chk("stall.valid1", v32, 1);
        for (int unsigned b = 0; b < 15; b++) beat32(vt[2].seed + b, 1'b0);
        a32.TVALID = 1'b1; a32.TDATA = vt[2].seed + 32'd15; a32.TLAST = 1'b1;
        @(negedge clk);
        chk("stall.tready", a32.TREADY, 0);
        repeat (4) @(negedge clk);
        chk("stall.tready_held", a32.TREADY, 0);
        chk_ent("stall.hold", vt[1], id32, op32, fl32, lk32, rk32, bt32, rs32);
        chk("stall.count_hold", cnt32, exp32);
        @(posedge clk); #1;
        rdy32 = 1'b1;
        @(negedge clk);
        chk("stall.tready_rel", a32.TREADY, 1);
        @(posedge clk); #1;
        a32.TVALID = 1'b0; a32.TLAST = 1'b0;
        exp32++;
        chk("coinc.valid", v32, 1);
        chk_ent("coinc", vt[2], id32, op32, fl32, lk32, rk32, bt32, rs32);
        chk("coinc.count", cnt32, exp32);
        @(posedge clk); #1;
        chk("coinc.valid_clr", v32, 0);

`ifdef RDMA_SQ_TLAST_CHECK_EN
        // Early TLAST on beat 5.
        send32(32'hDEAD_0000, 5, 4);
        exp_ferr++;
        chk("early.frame_err", fe32, 1);
        chk("early.valid", v32, 0);
        @(posedge clk); #1;
        chk("early.frame_err_clr", fe32, 0);
        send32(vt[3].seed, 16, 15);
        exp32++;
        chk_ent("early.next", vt[3], id32, op32, fl32, lk32, rk32, bt32, rs32);
        chk("early.count", cnt32, exp32);
        @(posedge clk); #1;
        // Missing TLAST, then 3 junk beats ending in TLAST.
        send32(32'hBAD0_0000, 16, 99);
        exp_ferr++;
        chk("miss.frame_err", fe32, 1);
        chk("miss.valid", v32, 0);
        send32(32'h0, 3, 2);
        chk("drain.valid", v32, 0);
        chk("drain.count", cnt32, exp32);
        send32(vt[0].seed, 16, 15);
        exp32++;
        chk_ent("drain.next", vt[0], id32, op32, fl32, lk32, rk32, bt32, rs32);
        chk("drain.next_count", cnt32, exp32);
        @(posedge clk); #1;
`else
        // TLAST ignored: early TLAST and missing final TLAST still frame by count.
        send32(vt[3].seed, 16, 4);
        exp32++;
        chk("notl.valid", v32, 1);
        chk_ent("notl", vt[3], id32, op32, fl32, lk32, rk32, bt32, rs32);
        chk("notl.count", cnt32, exp32);
        @(posedge clk); #1;
`endif

        // Reset mid-hold and mid-entry (beat 7).
        rdy32 = 1'b0;
        send32(vt[0].seed, 16, 15);
        send32(32'h7777_0000, 7, 99);
        #3;
        rst_n = 1'b0;
        #1;
        exp32 = 0;
        chk("arst.valid", v32, 0);
        chk("arst.id", id32, 0);
        chk("arst.lkey", lk32, 0);
        chk("arst.res", rs32[127:0], 0);
        chk("arst.count", cnt32, 0);
        chk("arst.tready", a32.TREADY, 1);
        chk("arst.v128_count", cnt128, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rdy32 = 1'b1;
        send32(vt[1].seed, 16, 15);
        exp32++;
        chk("post_rst.valid", v32, 1);
        chk_ent("post_rst", vt[1], id32, op32, fl32, lk32, rk32, bt32, rs32);
        chk("post_rst.count", cnt32, exp32);
        @(posedge clk); #1;

        chk("frame_err.pulses", n_ferr, exp_ferr);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rdma_sq_entry_parser.md
# rdma_sq_entry_parser

Parametrised AXI4-Stream send-queue (SQ) entry parser for the RDMA TX data-mover controller. It assembles fixed-size SQ entries from a stream of any supported data width and decodes them into RDMA descriptor fields. The decoded entry is held behind a valid/ready handshake, so the downstream command issuer can stall without data loss. It sits between the SQ fetch DMA stream and the data-mover command generator.

## Interface
- `C_S_AXIS_TDATA_WIDTH`, 32, stream width in bits; one of 32, 64, 128, 256, 512.
- `ENTRY_BYTES`, 64, SQ entry size in bytes; ≥48 and a multiple of `C_S_AXIS_TDATA_WIDTH/8`. Derived: `BEATS = ENTRY_BYTES*8/C_S_AXIS_TDATA_WIDTH`; `RES_W = (ENTRY_BYTES-40)*8`.
- `S_AXIS_ACLK`  in  1  single clock.
- `S_AXIS_ARESETN`  in  1  asynchronous, active-low reset.
- `S_AXIS_TVALID`  in  1  beat valid.
- `S_AXIS_TREADY`  out  1  beat accepted when TVALID&TREADY.
- `S_AXIS_TDATA`  in  C_S_AXIS_TDATA_WIDTH  little-endian entry bytes.
- `S_AXIS_TSTRB`  in  C_S_AXIS_TDATA_WIDTH/8  ignored.
- `S_AXIS_TLAST`  in  1  last beat of an entry.
- `rdma_id`  out  32  entry bytes 0-3.
- `rdma_opcode`  out  16  bytes 4-5.
- `rdma_flags`  out  16  bytes 6-7.
- `rdma_local_key`  out  64  bytes 8-15.
- `rdma_remote_key`  out  64  bytes 16-23.
- `rdma_btt`  out  128  bytes 24-39.
- `rdma_reserved`  out  RES_W  bytes 40..ENTRY_BYTES-1.
- `rdma_entry_valid`  out  1  decoded entry held on field outputs.
- `rdma_entry_ready`  in  1  consumer accepts the entry.
- `frame_err`  out  1  one-cycle pulse on a framing violation.
- `entry_count`  out  32  entries emitted since reset; wraps.

## Operation
- Assembly buffer (ENTRY_BYTES×8 bits) and beat counter `beat_cnt` (0..BEATS-1). An accepted beat is written at bit offset `beat_cnt*C_S_AXIS_TDATA_WIDTH`.
- Output register stage is separate from the assembly buffer, so entry N+1 can be assembled while entry N waits for `rdma_entry_ready`.
- FSM states:
  - RECV: accept beats; `beat_cnt` increments.
  - DRAIN: accept and discard beats until a beat with TLAST is accepted, then go to RECV with `beat_cnt`=0.
- Completing beat (beat_cnt==BEATS-1, accepted): all field outputs load from the buffer plus the current TDATA. `rdma_entry_valid`←1, `entry_count`+1, `beat_cnt`←0.
- TREADY = 0 only when in RECV, beat_cnt==BEATS-1, `rdma_entry_valid`=1 and `rdma_entry_ready`=0. Otherwise TREADY = 1, including in DRAIN.
- `rdma_entry_valid` clears on valid&ready unless a new entry completes in the same cycle; in that case the new entry loads and valid stays 1.
- Field outputs are stable while valid=1 and ready=0.
- Reset (asynchronous, any time): state RECV, `beat_cnt` 0, all field outputs 0, `rdma_entry_valid` 0, `frame_err` 0, `entry_count` 0. A partial entry is lost; TREADY=1 immediately.

## Timing
- Latency: `rdma_entry_valid` rises on the clock edge that accepts the completing beat, so it is visible in the next cycle.
- Throughput: one entry per BEATS cycles with no bubbles while the consumer keeps `rdma_entry_ready` high.
- BEATS=1 (e.g. 512-bit stream with 64-byte entries): every accepted beat completes an entry.
- TREADY depends combinationally on `rdma_entry_ready`; the consumer must not derive ready from TREADY.
- `frame_err` is a registered pulse, high for exactly one cycle after the violating beat is accepted.

## Configuration
- `RDMA_SQ_TLAST_CHECK_EN` defined:
  - Early TLAST (accepted with beat_cnt<BEATS-1): discard the partial entry, pulse `frame_err`, set `beat_cnt`←0, stay in RECV.
  - Missing TLAST on the completing beat: do not emit the entry, pulse `frame_err`, enter DRAIN.
- `RDMA_SQ_TLAST_CHECK_EN` undefined:
  - TLAST is ignored; entries are delimited by beat count only.
  - `frame_err` is tied 0; DRAIN is never entered.

## Test plan
- 32-bit, one entry with words 0x0..0xF and TLAST on beat 16, ready=1 -> valid for 1 cycle, `rdma_id`=0x0, `rdma_opcode`=0x0001, `rdma_flags`=0x0000, `rdma_local_key`=0x00000003_00000002, `rdma_reserved`[31:0]=0xA, `entry_count`=1.
- Two back-to-back entries, ready=0 until cycle 40 -> TREADY drops on beat 16 of entry 2; entry 1 is held stable; after ready, entry 2 is emitted with no beat lost.
- Valid&ready coincides with completion of the next entry -> valid stays 1, fields switch to the new entry, `entry_count` +2 overall.
- CHECK_EN: TLAST on beat 5 -> `frame_err` pulse, nothing emitted; the following clean entry decodes correctly. Missing TLAST on beat 16, then 3 junk beats with TLAST on the third -> one `frame_err`, no emission, back in RECV.
- C_S_AXIS_TDATA_WIDTH=128, ENTRY_BYTES=64 -> 4 beats per entry, same decoded values as the 32-bit case. Width 512 -> an entry every beat.
- Assert reset mid-entry (beat 7) and mid-hold -> all outputs 0 asynchronously; the next full entry decodes correctly.
